uart_rx_core: RTL

- UART serial receiver. Consumer of the 16x oversample tick produced by the phase-accumulator clock generator; that tick is used as a single-cycle enable, never as a clock.
- Synchronises the asynchronous rx line, detects and validates the start bit, and samples at mid-bit.
- Assembles LSB-first data and presents each byte on a valid/ready handshake toward the controller's register or FIFO side.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_sync.sv | 27 ++
 rtl/uart_rx_core.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam int   UART_OVERSAMPLE = 16;
  localparam logic UART_IDLE       = 1'b1;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA       = 3'd2,
    PARITY     = 3'd3,
    STOP       = 3'd4,
    BREAK_WAIT = 3'd5
  } rx_state_t;

  // XOR reduction of up to nine data bits (unused upper bits are zero).
  function automatic logic parity_of(input logic [8:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-stage synchroniser for an asynchronous level input. The stages
// preset to the UART idle level so reset never fakes a start bit.
module uart_sync
  import uart_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the raw input through the flop chain; preset to idle on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= {STAGES{UART_IDLE}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: synchronises rx_i, validates the start bit, samples each
// bit at mid-period using the oversample enable tick_i, and offers the
// assembled LSB-first byte on a valid/ready handshake.
// Optional parity bit and parity_err_o port: define UART_RX_PARITY_EN.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = UART_DATA_BITS,
  parameter int OVERSAMPLE  = UART_OVERSAMPLE,
  parameter int SYNC_STAGES = 2,
  parameter int PARITY_ODD  = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 tick_i,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err_o
`endif
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  rx_state_t            state;
  rx_state_t            state_nxt;
  logic                 rx_s;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 at_half;
  logic                 at_full;
  logic                 frame_done;
  logic                 accept;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit;
`endif

  uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk_i),
    .rst (rst_i),
    .d   (rx_i),
    .q   (rx_s)
  );

  assign at_half    = (tick_cnt == HALF_LAST);
  assign at_full    = (tick_cnt == FULL_LAST);
  assign frame_done = tick_i && (state == STOP) && at_full;
  assign accept     = valid_o && ready_i;

  // Next-state decode; every transition is gated by the oversample tick.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (tick_i && !rx_s) state_nxt = START;
        else                 state_nxt = IDLE;
      end
      START: begin
        if (tick_i && at_half) state_nxt = rx_s ? IDLE : DATA;
        else                   state_nxt = START;
      end
      DATA: begin
        if (tick_i && at_full && (bit_cnt == BIT_LAST)) begin
`ifdef UART_RX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end else begin
          state_nxt = DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick_i && at_full) state_nxt = STOP;
        else                   state_nxt = PARITY;
      end
`endif
      STOP: begin
        if (tick_i && at_full) state_nxt = rx_s ? IDLE : BREAK_WAIT;
        else                   state_nxt = STOP;
      end
      BREAK_WAIT: begin
        if (tick_i && rx_s) state_nxt = IDLE;
        else                state_nxt = BREAK_WAIT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register, tick/bit counters and the LSB-first shift register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      busy_o   <= 1'b0;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
    end else begin
      state  <= state_nxt;
      busy_o <= (state_nxt != IDLE);
      if (tick_i) begin
        // Restart the bit-period count on every state change and mid-bit sample.
        if ((state_nxt != state) || at_full || (state == IDLE) || (state == BREAK_WAIT)) begin
          tick_cnt <= '0;
        end else begin
          tick_cnt <= tick_cnt + TW'(1);
        end
        if (state == START) begin
          bit_cnt <= '0;
        end else if ((state == DATA) && at_full) begin
          bit_cnt <= bit_cnt + BW'(1);
          shift   <= {rx_s, shift[DATA_BITS-1:1]};
        end
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  // Capture the received parity bit at its mid-bit point.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      par_bit <= 1'b0;
    end else if (tick_i && (state == PARITY) && at_full) begin
      par_bit <= rx_s;
    end
  end
`endif

  // Output handshake: load on stop-bit sample, clear on transfer, flag overrun.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_o       <= '0;
      valid_o      <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_o <= 1'b0;
`endif
    end else if (frame_done) begin
      if (!valid_o || ready_i) begin
        // Slot free, or the old byte leaves this very cycle.
        data_o       <= shift;
        valid_o      <= 1'b1;
        frame_err_o  <= ~rx_s;
        overrun_o    <= 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err_o <= par_bit ^ parity_of(9'(shift)) ^ PARITY_ODD[0];
`endif
      end else begin
        overrun_o <= 1'b1;
      end
    end else if (accept) begin
      valid_o      <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_o <= 1'b0;
`endif
    end
  end

endmodule
